// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and
// the majority-vote / parity helpers used by rx and tx.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } uart_state_t;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic par_bit(input logic [8:0] d, input int mode);
        return (^d) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one clk-wide tick every DIV clocks.
// With DIV=1 the tick is permanently high.
module uart_baud_gen #(
    parameter int CLK_FREQ   = 1_600_000,
    parameter int BAUD       = 100_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote,
// parity/framing/overrun detection and a valid/ready output stage.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 1_600_000,
    parameter int BAUD       = 100_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int BCW = $clog2(DATA_BITS + 1);

    uart_state_t          state, state_n;
    logic                 tick;
    logic                 rx_m, rx_s;
    logic [3:0]           scnt;
    logic [1:0]           samp;
    logic [BCW-1:0]       bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed, perr_acc, ferr_acc;
    logic                 sbit, at9, start, last_bit, ferr_n, commit;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        sbit     = maj3({samp, rx_s});
        at9      = tick && (scnt == 4'd9);
        start    = (state == S_IDLE) && armed && !rx_s;
        last_bit = (bcnt == BCW'(DATA_BITS - 1));
        ferr_n   = ferr_acc | !sbit;
        commit   = at9 && (((state == S_STOP1) && (STOP_BITS == 1))
                   || (state == S_STOP2));
        busy     = (state != S_IDLE) && (state != S_START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_START;
            S_START:  if (at9) state_n = sbit ? S_IDLE : S_DATA;
            S_DATA:   if (at9 && last_bit)
                          state_n = (PARITY == PAR_NONE) ? S_STOP1 : S_PARITY;
            S_PARITY: if (at9) state_n = S_STOP1;
            S_STOP1:  if (at9) state_n = (STOP_BITS == 2) ? S_STOP2 : S_IDLE;
            S_STOP2:  if (at9) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            scnt       <= '0;
            samp       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            armed      <= 1'b0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            overrun <= 1'b0;
            if (tick) scnt <= scnt + 4'd1;
            if (start) scnt <= '0;
            if (tick && scnt == 4'd7) samp[0] <= rx_s;
            if (tick && scnt == 4'd8) samp[1] <= rx_s;
            // Re-arm only after a high sample, so a held break cannot retrigger.
            if (state == S_IDLE && tick && rx_s) armed <= 1'b1;
            if (start) armed <= 1'b0;
            if (at9) begin
                case (state)
                    S_START: begin
                        bcnt     <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                    S_DATA: begin
                        shreg <= {sbit, shreg[DATA_BITS-1:1]};
                        bcnt  <= last_bit ? '0 : bcnt + 1'b1;
                    end
                    S_PARITY: perr_acc <= (sbit != par_bit(9'(shreg), PARITY));
                    S_STOP1,
                    S_STOP2:  ferr_acc <= ferr_n;
                    default: ;
                endcase
            end
            if (commit && (!valid || ready)) begin
                data       <= shreg;
                parity_err <= perr_acc;
                frame_err  <= ferr_n;
                valid      <= 1'b1;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2)
// driven by a vector table plus multi-cycle corner sequences.
module tb_uart_rx_cfg;

    typedef struct {
        int         k;
        logic [8:0] w;
        logic       pb;
        logic       s1;
        logic       s2;
        logic [8:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_l[3];
    logic       rdy[3];
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic [8:0] d_m[3];
    logic       v_m[3], pe_m[3], fe_m[3], ov_m[3], bz_m[3];
    int         vcnt[3] = '{0, 0, 0};
    int         ocnt[3] = '{0, 0, 0};
    int         bzc[3]  = '{0, 0, 0};
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[13];

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_l[0]), .data(data_a),
        .valid(v_m[0]), .ready(rdy[0]), .parity_err(pe_m[0]),
        .frame_err(fe_m[0]), .overrun(ov_m[0]), .busy(bz_m[0])
    );

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_l[1]), .data(data_b),
        .valid(v_m[1]), .ready(rdy[1]), .parity_err(pe_m[1]),
        .frame_err(fe_m[1]), .overrun(ov_m[1]), .busy(bz_m[1])
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .rx(rx_l[2]), .data(data_c),
        .valid(v_m[2]), .ready(rdy[2]), .parity_err(pe_m[2]),
        .frame_err(fe_m[2]), .overrun(ov_m[2]), .busy(bz_m[2])
    );

    assign d_m[0] = {1'b0, data_a};
    assign d_m[1] = {1'b0, data_b};
    assign d_m[2] = {2'b0, data_c};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (v_m[k])  vcnt[k] <= vcnt[k] + 1;
            if (ov_m[k]) ocnt[k] <= ocnt[k] + 1;
            if (bz_m[k]) bzc[k]  <= bzc[k] + 1;
        end
    end

    function automatic int nb(input int k);
        return (k == 2) ? 7 : 8;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int k, input logic b);
        rx_l[k] = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input int k, input logic [8:0] w,
                              input logic pb, input logic s1, input logic s2);
        @(negedge clk);
        drive_bit(k, 1'b0);
        for (int i = 0; i < nb(k); i++) drive_bit(k, w[i]);
        if (k != 0) drive_bit(k, pb);
        drive_bit(k, s1);
        if (k == 2) drive_bit(k, s2);
    endtask

    task automatic run_vec(input string name, input vec_t v,
                           input int low_after);
        int         c0;
        logic       got;
        logic [8:0] d;
        logic       pe, fe, bz;
        c0  = vcnt[v.k];
        got = 1'b0;
        d   = '0;
        pe  = 1'b0;
        fe  = 1'b0;
        bz  = 1'b1;
        fork
            send_frame(v.k, v.w, v.pb, v.s1, v.s2);
            begin
                for (int i = 0; i < 400 && !got; i++) begin
                    @(negedge clk);
                    if (v_m[v.k]) begin
                        got = 1'b1;
                        d   = d_m[v.k];
                        pe  = pe_m[v.k];
                        fe  = fe_m[v.k];
                        bz  = bz_m[v.k];
                    end
                end
            end
        join
        repeat (low_after) @(negedge clk);
        rx_l[v.k] = 1'b1;
        repeat (32) @(negedge clk);
        chk({name, "_valid_seen"}, 32'(got), 1);
        chk({name, "_data"}, 32'(d), 32'(v.ed));
        chk({name, "_parity_err"}, 32'(pe), 32'(v.epe));
        chk({name, "_frame_err"}, 32'(fe), 32'(v.efe));
        chk({name, "_busy_at_valid"}, 32'(bz), 0);
        chk({name, "_valid_cycles"}, 32'(vcnt[v.k] - c0), 1);
    endtask

    task automatic chk_all_zero(input string name);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_%0d", name, k),
                32'({d_m[k], v_m[k], pe_m[k], fe_m[k], ov_m[k], bz_m[k]}), 0);
    endtask

    initial begin
        int c0, o0, b0;
        rx_l  = '{1'b1, 1'b1, 1'b1};
        rdy   = '{1'b1, 1'b1, 1'b1};
        reset = 1'b1;
        //           k  word    pb    s1    s2    data    pe    fe
        tbl[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
        tbl[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
        tbl[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
        tbl[3]  = '{1, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
        tbl[4]  = '{1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
        tbl[5]  = '{1, 9'h001, 1'b1, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
        tbl[6]  = '{2, 9'h05A, 1'b1, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};
        tbl[7]  = '{2, 9'h07F, 1'b1, 1'b1, 1'b1, 9'h07F, 1'b1, 1'b0};
        tbl[8]  = '{2, 9'h015, 1'b0, 1'b1, 1'b0, 9'h015, 1'b0, 1'b1};
        tbl[9]  = '{0, 9'h033, 1'b0, 1'b0, 1'b0, 9'h033, 1'b0, 1'b1};
        tbl[10] = '{0, 9'h081, 1'b0, 1'b1, 1'b1, 9'h081, 1'b0, 1'b0};
        tbl[11] = '{0, 9'h05C, 1'b0, 1'b1, 1'b1, 9'h05C, 1'b0, 1'b0};
        tbl[12] = '{2, 9'h05A, 1'b1, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;
        repeat (32) @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], 0);

        // Stop bit low then a 40-bit-time break: exactly one word.
        run_vec("break", tbl[9], 40 * 16);
        run_vec("after_break", tbl[10], 0);

        // Short low glitch must be rejected as a false start.
        c0 = vcnt[0];
        b0 = bzc[0];
        @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_no_valid", 32'(vcnt[0] - c0), 0);
        chk("glitch_no_busy", 32'(bzc[0] - b0), 0);
        run_vec("after_glitch", tbl[11], 0);

        // Consumer stalled: second frame is dropped with one overrun pulse.
        rdy[0] = 1'b0;
        o0 = ocnt[0];
        send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        chk("ovr_valid_held", 32'(v_m[0]), 1);
        chk("ovr_data_held", 32'(d_m[0]), 32'h11);
        chk("ovr_pulses", 32'(ocnt[0] - o0), 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("ovr_consumed", 32'(v_m[0]), 0);
        repeat (16) @(negedge clk);

        // Reset in the middle of data bit 3.
        c0 = vcnt[2];
        @(negedge clk);
        rx_l[2] = 1'b0;
        repeat (16 * 4 + 8) @(negedge clk);
        chk("busy_before_reset", 32'(bz_m[2]), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset   = 1'b0;
        rx_l[2] = 1'b1;
        repeat (64) @(negedge clk);
        chk("no_partial_frame", 32'(vcnt[2] - c0), 0);
        run_vec("after_reset", tbl[12], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
